// File: rtl/upak_pkg.sv
// Shared types and helpers for the symbol-to-word packer.
// Order codes, o_nbits width and bit/byte mirror functions.
package upak_pkg;

  typedef enum logic [3:0] {
    FM2_1    = 4'd1,
    QPSK_2   = 4'd2,
    PSK8_3   = 4'd3,
    QAM16_4  = 4'd4,
    QAM32_5  = 4'd5,
    QAM64_6  = 4'd6,
    QAM128_7 = 4'd7,
    QAM256_8 = 4'd8
  } order_e;

  function automatic int nbits_w(input int w);
    return $clog2(w + 1);
  endfunction

  // Reverse the bit order inside every byte.
  function automatic logic [63:0] mirror_byte(
    input logic [63:0] x
  );
    logic [63:0] r;
    for (int i = 0; i < 64; i++)
      r[i] = x[(i & ~7) | (7 - (i & 7))];
    return r;
  endfunction

  // Reverse the order of the low nob bytes.
  function automatic logic [63:0] mirror_word(
    input logic [63:0] x,
    input int          nob
  );
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (i < nob && j == nob - 1 - i)
          r[8*i +: 8] = x[8*j +: 8];
    return r;
  endfunction

endpackage

// File: rtl/upak_if.sv
// Symbol-in / word-out bundle of the packer.
// slave is the packer view, master the driver view.
interface upak_if
  import upak_pkg::*;
#(
  parameter int NOB    = 4,
  parameter int MAXORD = 8
);
  localparam int W   = NOB * 8;
  localparam int NBW = nbits_w(W);

  logic [MAXORD-1:0] i_data;
  logic [3:0]        i_order;
  logic              i_valid;
  logic              o_ready;
  logic              i_flush;
  logic              i_ismirrordata;
  logic              i_ismirrorbyte;
  logic              i_ismirrorword;
  logic              i_isndata;
  logic [W-1:0]      o_data;
  logic [NBW-1:0]    o_nbits;
  logic              o_valid;
  logic              i_ready;
  logic              o_ord_err;

  modport slave (
    input  i_data, i_order, i_valid, i_flush,
    input  i_ismirrordata, i_ismirrorbyte,
    input  i_ismirrorword, i_isndata, i_ready,
    output o_ready, o_data, o_nbits,
    output o_valid, o_ord_err
  );

  modport master (
    output i_data, i_order, i_valid, i_flush,
    output i_ismirrordata, i_ismirrorbyte,
    output i_ismirrorword, i_isndata, i_ready,
    input  o_ready, o_data, o_nbits,
    input  o_valid, o_ord_err
  );

endinterface

// File: rtl/upak_fmt.sv
// Output word shaping: invert valid bits, then
// mirror bits per byte, then mirror byte order.
module upak_fmt
  import upak_pkg::*;
#(
  parameter  int NOB = 4,
  localparam int W   = NOB * 8,
  localparam int NBW = nbits_w(W)
) (
  input  logic [W-1:0]   i_word,
  input  logic [NBW-1:0] i_nbits,
  input  logic           i_ndata,
  input  logic           i_mbyte,
  input  logic           i_mword,
  output logic [W-1:0]   o_word
);
  logic [W-1:0] mask;
  logic [W-1:0] inv;
  logic [63:0]  t;
  logic         unused_t;

  // Valid bits are MSB-aligned; pad LSBs are never inverted.
  always_comb begin
    mask = ~({W{1'b1}} >> i_nbits);
    inv  = i_ndata ? (i_word ^ mask) : i_word;
    t    = 64'(inv);
    if (i_mbyte) t = mirror_byte(t);
    if (i_mword) t = mirror_word(t, NOB);
    o_word = t[W-1:0];
  end

  assign unused_t = ^t;

endmodule

// File: rtl/upak_stream.sv
// Packs 1..MAXORD-bit symbols into NOB-byte words with
// valid/ready on both sides and partial-word flush.
module upak_stream
  import upak_pkg::*;
#(
  parameter int NOB    = 4,
  parameter int MAXORD = 8
) (
  input logic   i_clk,
  input logic   i_rst,
  upak_if.slave bus
);
  localparam int W   = NOB * 8;
  localparam int AW  = W + MAXORD - 1;
  localparam int CW  = $clog2(AW + 1);
  localparam int NBW = nbits_w(W);
  localparam logic [CW-1:0] WC = CW'(W);

  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic [W-1:0]      data_q, data_d;
  logic [NBW-1:0]    nbits_q, nbits_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic              ord_ok, ready, accept;
  logic              out_free, full_x, flush_x, load;
  logic [MAXORD-1:0] rev_full, sym;
  logic [AW-1:0]     sym_w;
  logic [AW+W-1:0]   ext;
  logic [W-1:0]      word_raw, word_fmt;
  logic [NBW-1:0]    nbits_sel;
  logic              unused_ext;

  // Handshake, transfer decisions and oldest-bits extraction.
  always_comb begin
    ord_ok = (bus.i_order != 4'd0)
           && (bus.i_order <= 4'(MAXORD));
    out_free = ~valid_q | bus.i_ready;
    full_x   = (cnt_q >= WC) & out_free;
    flush_x  = flush_pend_q & (cnt_q != '0)
             & (cnt_q < WC) & out_free;
    load     = full_x | flush_x;
    ready    = ~flush_pend_q & ((cnt_q < WC) | full_x);
    accept   = bus.i_valid & ready;
    nbits_sel = full_x ? NBW'(W) : NBW'(cnt_q);
    ext      = {acc_q, {W{1'b0}}} >> cnt_q;
    word_raw = ext[W-1:0];
  end

  // Symbol bits in arrival order, oldest at the top.
  always_comb begin
    for (int i = 0; i < MAXORD; i++)
      rev_full[i] = bus.i_data[MAXORD-1-i];
    sym = bus.i_ismirrordata
        ? (rev_full >> (4'(MAXORD) - bus.i_order))
        : bus.i_data;
    sym_w = AW'(sym) & ~({AW{1'b1}} << bus.i_order);
  end

  upak_fmt #(.NOB(NOB)) u_fmt (
    .i_word  (word_raw),
    .i_nbits (nbits_sel),
    .i_ndata (bus.i_isndata),
    .i_mbyte (bus.i_ismirrorbyte),
    .i_mword (bus.i_ismirrorword),
    .o_word  (word_fmt)
  );

  // Next state: drain, append, output load, flush tracking.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    data_d       = data_q;
    nbits_d      = nbits_q;
    valid_d      = valid_q & ~bus.i_ready;
    err_d        = accept & ~ord_ok;
    if (full_x)       cnt_d = cnt_q - WC;
    else if (flush_x) cnt_d = '0;
    if (accept & ord_ok) begin
      acc_d = (acc_q << bus.i_order) | sym_w;
      cnt_d = cnt_d + CW'(bus.i_order);
    end
    if (load) begin
      data_d  = word_fmt;
      nbits_d = nbits_sel;
      valid_d = 1'b1;
    end
    if (bus.i_flush)
      flush_pend_d = 1'b1;
    else if (flush_x | (cnt_q == '0))
      flush_pend_d = 1'b0;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      data_q       <= '0;
      nbits_q      <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      data_q       <= data_d;
      nbits_q      <= nbits_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign unused_ext    = ^ext;
  assign bus.o_ready   = ready;
  assign bus.o_data    = data_q;
  assign bus.o_nbits   = nbits_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_ord_err = err_q;

endmodule

// File: tb/tb_upak_stream.sv
// Directed bench for upak_stream with a 1-byte and a
// 2-byte instance sharing clock and reset.
module tb_upak_stream;
  import upak_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [7:0]  q1d[$];
  int          q1n[$];
  logic [15:0] q2d[$];
  int          q2n[$];

  upak_if #(.NOB(1), .MAXORD(8)) b1();
  upak_if #(.NOB(2), .MAXORD(8)) b2();

  upak_stream #(.NOB(1), .MAXORD(8)) u1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b1)
  );

  upak_stream #(.NOB(2), .MAXORD(8)) u2 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b2)
  );

  always #5 clk = ~clk;

  // Words that transfer at the coming edge.
  always @(negedge clk) begin
    if (b1.o_valid && b1.i_ready) begin
      q1d.push_back(b1.o_data);
      q1n.push_back(int'(b1.o_nbits));
    end
    if (b2.o_valid && b2.i_ready) begin
      q2d.push_back(b2.o_data);
      q2n.push_back(int'(b2.o_nbits));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [7:0] d,
                       input logic [3:0] o);
    int k;
    b1.i_data  = d;
    b1.i_order = o;
    b1.i_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!b1.o_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (b1.o_ready !== 1'b1) begin
      bad++;
      $display("FAIL send1_ready got=%b exp=1",
               b1.o_ready);
    end
    @(posedge clk);
    #1;
    b1.i_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] d,
                       input logic [3:0] o);
    int k;
    b2.i_data  = d;
    b2.i_order = o;
    b2.i_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!b2.o_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (b2.o_ready !== 1'b1) begin
      bad++;
      $display("FAIL send2_ready got=%b exp=1",
               b2.o_ready);
    end
    @(posedge clk);
    #1;
    b2.i_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    total++;
    if (b1.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got=%b exp=0", b1.o_valid);
    end
    total++;
    if (b1.o_data !== 8'h00) begin
      bad++;
      $display("FAIL rst_data got=%h exp=00", b1.o_data);
    end
    total++;
    if (b1.o_nbits !== 4'd0) begin
      bad++;
      $display("FAIL rst_nbits got=%0d exp=0", b1.o_nbits);
    end
    total++;
    if (b1.o_ord_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_err got=%b exp=0", b1.o_ord_err);
    end
    total++;
    if (b2.o_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready got=%b exp=1", b2.o_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic;
    int i0;
    i0 = q1d.size();
    send1(8'd3, QPSK_2);
    send1(8'd0, QPSK_2);
    send1(8'd2, QPSK_2);
    send1(8'd1, QPSK_2);
    idle(3);
    total++;
    if (q1d.size() - i0 !== 1) begin
      bad++;
      $display("FAIL basic_cnt got=%0d exp=1",
               q1d.size() - i0);
    end else begin
      total++;
      if (q1d[i0] !== 8'hC9 || q1n[i0] !== 8) begin
        bad++;
        $display("FAIL basic got=%h/%0d exp=c9/8",
                 q1d[i0], q1n[i0]);
      end
    end
    i0 = q1d.size();
    b1.i_ismirrorbyte = 1'b1;
    send1(8'd3, QPSK_2);
    send1(8'd0, QPSK_2);
    send1(8'd2, QPSK_2);
    send1(8'd1, QPSK_2);
    idle(3);
    b1.i_ismirrorbyte = 1'b0;
    total++;
    if (q1d.size() - i0 !== 1 || q1d[i0] !== 8'h93) begin
      bad++;
      $display("FAIL mbyte got=%h exp=93",
               q1d[q1d.size()-1]);
    end
  endtask

  task automatic test_flush;
    int i0;
    i0 = q1d.size();
    send1(8'd5, PSK8_3);
    send1(8'd6, PSK8_3);
    send1(8'd3, PSK8_3);
    idle(3);
    total++;
    if (q1d.size() - i0 !== 1 || q1d[i0] !== 8'hB9) begin
      bad++;
      $display("FAIL straddle got=%h exp=b9",
               q1d[q1d.size()-1]);
    end
    i0 = q1d.size();
    b1.i_flush = 1'b1;
    idle(1);
    b1.i_flush = 1'b0;
    idle(4);
    total++;
    if (q1d.size() - i0 !== 1 || q1d[i0] !== 8'h80
        || q1n[i0] !== 1) begin
      bad++;
      $display("FAIL flush1 got=%h/%0d exp=80/1",
               q1d[q1d.size()-1], q1n[q1n.size()-1]);
    end
    i0 = q1d.size();
    b1.i_flush = 1'b1;
    idle(1);
    b1.i_flush = 1'b0;
    idle(4);
    total++;
    if (q1d.size() - i0 !== 0) begin
      bad++;
      $display("FAIL flush_empty got=%0d exp=0",
               q1d.size() - i0);
    end
    total++;
    if (b1.o_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_ready got=%b exp=1",
               b1.o_ready);
    end
    i0 = q1d.size();
    b1.i_flush = 1'b1;
    send1(8'd5, PSK8_3);
    b1.i_flush = 1'b0;
    idle(4);
    total++;
    if (q1d.size() - i0 !== 1 || q1d[i0] !== 8'hA0
        || q1n[i0] !== 3) begin
      bad++;
      $display("FAIL flush_sym got=%h/%0d exp=a0/3",
               q1d[q1d.size()-1], q1n[q1n.size()-1]);
    end
  endtask

  task automatic test_word;
    int i0;
    i0 = q2d.size();
    send2(8'h12, QAM256_8);
    send2(8'h34, QAM256_8);
    idle(3);
    total++;
    if (q2d.size() - i0 !== 1 || q2d[i0] !== 16'h1234
        || q2n[i0] !== 16) begin
      bad++;
      $display("FAIL word got=%h exp=1234",
               q2d[q2d.size()-1]);
    end
    i0 = q2d.size();
    b2.i_ismirrorword = 1'b1;
    send2(8'h12, QAM256_8);
    send2(8'h34, QAM256_8);
    idle(3);
    b2.i_ismirrorword = 1'b0;
    total++;
    if (q2d.size() - i0 !== 1 || q2d[i0] !== 16'h3412) begin
      bad++;
      $display("FAIL mword got=%h exp=3412",
               q2d[q2d.size()-1]);
    end
    i0 = q2d.size();
    b2.i_isndata = 1'b1;
    send2(8'h12, QAM256_8);
    send2(8'h34, QAM256_8);
    idle(3);
    b2.i_isndata = 1'b0;
    total++;
    if (q2d.size() - i0 !== 1 || q2d[i0] !== 16'hEDCB) begin
      bad++;
      $display("FAIL ndata got=%h exp=edcb",
               q2d[q2d.size()-1]);
    end
    i0 = q2d.size();
    b2.i_ismirrordata = 1'b1;
    send2(8'h12, QAM256_8);
    send2(8'h34, QAM256_8);
    idle(3);
    b2.i_ismirrordata = 1'b0;
    total++;
    if (q2d.size() - i0 !== 1 || q2d[i0] !== 16'h482C) begin
      bad++;
      $display("FAIL mdata got=%h exp=482c",
               q2d[q2d.size()-1]);
    end
  endtask

  task automatic test_back_to_back;
    int i0;
    int sent;
    int win;
    i0   = q1d.size();
    sent = 0;
    win  = 0;
    for (int c = 0; c < 60; c++) begin
      b1.i_ready = (c >= 10);
      b1.i_valid = (sent < 20);
      b1.i_data  = 8'h40 + 8'(sent);
      b1.i_order = QAM256_8;
      @(negedge clk);
      if (c == 5) begin
        total++;
        if (b1.o_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_ready got=%b exp=0",
                   b1.o_ready);
        end
      end
      if (c == 9) begin
        total++;
        if (b1.o_data !== 8'h40 || b1.o_valid !== 1'b1) begin
          bad++;
          $display("FAIL stall_hold got=%h/%b exp=40/1",
                   b1.o_data, b1.o_valid);
        end
      end
      if (b1.i_valid && b1.o_ready) begin
        sent++;
        if (c >= 10 && c < 18) win++;
      end
      @(posedge clk);
      #1;
    end
    b1.i_valid = 1'b0;
    b1.i_ready = 1'b1;
    idle(2);
    total++;
    if (win !== 8) begin
      bad++;
      $display("FAIL rate got=%0d exp=8", win);
    end
    total++;
    if (q1d.size() - i0 !== 20) begin
      bad++;
      $display("FAIL b2b_cnt got=%0d exp=20",
               q1d.size() - i0);
    end else begin
      for (int i = 0; i < 20; i++) begin
        total++;
        if (q1d[i0+i] !== 8'h40 + 8'(i)) begin
          bad++;
          $display("FAIL b2b_%0d got=%h exp=%h", i,
                   q1d[i0+i], 8'h40 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_order;
    int i0;
    i0 = q1d.size();
    send1(8'hA, QAM16_4);
    send1(8'h3, QPSK_2);
    send1(8'hF, 4'd0);
    total++;
    if (b1.o_ord_err !== 1'b1) begin
      bad++;
      $display("FAIL err0 got=%b exp=1", b1.o_ord_err);
    end
    send1(8'hFF, 4'd9);
    total++;
    if (b1.o_ord_err !== 1'b1) begin
      bad++;
      $display("FAIL err9 got=%b exp=1", b1.o_ord_err);
    end
    idle(1);
    total++;
    if (b1.o_ord_err !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse got=%b exp=0",
               b1.o_ord_err);
    end
    send1(8'h1, QPSK_2);
    idle(3);
    total++;
    if (q1d.size() - i0 !== 1 || q1d[i0] !== 8'hAD) begin
      bad++;
      $display("FAIL mixed got=%h exp=ad",
               q1d[q1d.size()-1]);
    end
  endtask

  task automatic test_reset_mid;
    int i0;
    i0 = q1d.size();
    b1.i_ready = 1'b0;
    send1(8'h77, QAM256_8);
    send1(8'h15, QAM32_5);
    idle(1);
    total++;
    if (b1.o_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst got=%b exp=1", b1.o_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (b1.o_valid !== 1'b0 || b1.o_data !== 8'h00
        || b1.o_nbits !== 4'd0
        || b1.o_ord_err !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got=%b/%h/%0d exp=0/00/0",
               b1.o_valid, b1.o_data, b1.o_nbits);
    end
    @(negedge clk);
    rst = 1'b0;
    b1.i_ready = 1'b1;
    idle(1);
    send1(8'h3C, QAM256_8);
    idle(3);
    total++;
    if (q1d.size() - i0 !== 1 || q1d[i0] !== 8'h3C
        || q1n[i0] !== 8) begin
      bad++;
      $display("FAIL post_rst got=%h n=%0d exp=3c",
               q1d[q1d.size()-1], q1d.size() - i0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    b1.i_data = '0; b1.i_order = '0; b1.i_valid = 1'b0;
    b1.i_flush = 1'b0; b1.i_ismirrordata = 1'b0;
    b1.i_ismirrorbyte = 1'b0; b1.i_ismirrorword = 1'b0;
    b1.i_isndata = 1'b0; b1.i_ready = 1'b1;
    b2.i_data = '0; b2.i_order = '0; b2.i_valid = 1'b0;
    b2.i_flush = 1'b0; b2.i_ismirrordata = 1'b0;
    b2.i_ismirrorbyte = 1'b0; b2.i_ismirrorword = 1'b0;
    b2.i_isndata = 1'b0; b2.i_ready = 1'b1;
    test_reset;
    test_basic;
    test_flush;
    test_word;
    test_back_to_back;
    test_order;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
